// File: rtl/gp_regs_pkg.sv
// Shared definitions for the general-purpose register file: default
// geometry, the default-width address type and the per-index reset value.
package gp_regs_pkg;

  localparam int DEFAULT_DATA_W   = 8;
  localparam int DEFAULT_NUM_REGS = 4;
  localparam int DEFAULT_ADDR_W   = (DEFAULT_NUM_REGS > 1) ? $clog2(DEFAULT_NUM_REGS) : 1;

  typedef logic [DEFAULT_ADDR_W-1:0] addr_t;

  // Register i comes out of reset holding 2 << i; callers truncate to DATA_W.
  function automatic logic [63:0] reset_value(input int idx);
    return 64'd2 << idx;
  endfunction

endpackage

// File: rtl/gp_reg_scoreboard.sv
// Pending-write scoreboard for gp_reg_file. A lock marks a register as
// awaiting a producer; a write retires it. Protocol violations (out-of-range
// address, lock of an already-pending register, write to a register nobody
// locked) raise a sticky error that only err_clr or reset removes.
module gp_reg_scoreboard
  import gp_regs_pkg::*;
#(
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int ZERO_REG = 0,
  parameter int ADDR_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                lock_en,
  input  logic [ADDR_W-1:0]   lock_addr,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic                err_clr,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                err
);

  // Register 0 is hard-wired in ZERO_REG builds, so it never tracks a lock.
  localparam logic [NUM_REGS-1:0] LIVE_MASK =
    (ZERO_REG != 0) ? {{(NUM_REGS-1){1'b1}}, 1'b0} : {NUM_REGS{1'b1}};

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                err_q, err_d;
  logic [NUM_REGS-1:0] wr_hot, lk_hot;
  logic [NUM_REGS-1:0] wr_sel, lk_sel;
  logic                wr_oob, lk_oob, lock_clash, orphan_wr, err_evt;

  // One-hot decode of both addresses; an all-zero result means out of range.
  always_comb begin
    wr_hot = '0;
    lk_hot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_addr == ADDR_W'(i)) wr_hot[i] = 1'b1;
      if (lock_addr == ADDR_W'(i)) lk_hot[i] = 1'b1;
    end
  end

  // Next busy/err state: the lock is applied after the write so that a
  // same-cycle lock+write on one register leaves it pending (new producer).
  always_comb begin
    wr_sel     = {NUM_REGS{wr_en}} & wr_hot & LIVE_MASK;
    lk_sel     = {NUM_REGS{lock_en}} & lk_hot & LIVE_MASK;
    wr_oob     = wr_en & ~(|wr_hot);
    lk_oob     = lock_en & ~(|lk_hot);
    lock_clash = |(lk_sel & busy_q & ~wr_sel);
    orphan_wr  = |(wr_sel & ~busy_q);
    err_evt    = wr_oob | lk_oob | lock_clash | orphan_wr;
    busy_d     = (busy_q & ~wr_sel) | lk_sel;
    err_d      = err_evt | (err_q & ~err_clr);
  end

  // State registers; reset discards whatever strobes are present.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign busy_vec = busy_q;
  assign err      = err_q;

endmodule

// File: rtl/gp_reg_file.sv
// General-purpose register file: one write port, two combinational read
// ports, per-register pending-write tracking via gp_reg_scoreboard.
// Optional write-through forwarding is enabled by defining
// GP_REG_FILE_BYPASS_EN; without it a write is visible the following cycle.
module gp_reg_file
  import gp_regs_pkg::*;
#(
  parameter  int DATA_W   = DEFAULT_DATA_W,
  parameter  int NUM_REGS = DEFAULT_NUM_REGS,
  parameter  int ZERO_REG = 0,
  localparam int ADDR_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [ADDR_W-1:0]   rd_addr_a,
  input  logic [ADDR_W-1:0]   rd_addr_b,
  output logic [DATA_W-1:0]   rd_data_a,
  output logic [DATA_W-1:0]   rd_data_b,
  input  logic                lock_en,
  input  logic [ADDR_W-1:0]   lock_addr,
  output logic                busy_a,
  output logic                busy_b,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                err,
  input  logic                err_clr
);

  localparam logic [NUM_REGS-1:0] LIVE_MASK =
    (ZERO_REG != 0) ? {{(NUM_REGS-1){1'b1}}, 1'b0} : {NUM_REGS{1'b1}};

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] wr_sel;

  gp_reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ZERO_REG (ZERO_REG),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .lock_en   (lock_en),
    .lock_addr (lock_addr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .err_clr   (err_clr),
    .busy_vec  (busy_vec),
    .err       (err)
  );

  // Decode the write onto writable registers; out-of-range writes select none.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_en && (wr_addr == ADDR_W'(i))) wr_sel[i] = 1'b1;
    end
    wr_sel = wr_sel & LIVE_MASK;
  end

  // Next-state of the storage array.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = wr_sel[i] ? wr_data : regs_q[i];
    end
  end

  // Storage with per-index reset values; register 0 stays 0 in ZERO_REG builds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= LIVE_MASK[i] ? DATA_W'(reset_value(i)) : '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

`ifdef GP_REG_FILE_BYPASS_EN
  logic byp_a, byp_b;
`endif

  // Read muxes: stored value (0 for hard-wired or out-of-range), optionally
  // overridden by the in-flight write; the busy flag follows the same index.
  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    busy_a    = 1'b0;
    busy_b    = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr_a == ADDR_W'(i)) begin
        rd_data_a = LIVE_MASK[i] ? regs_q[i] : '0;
        busy_a    = busy_vec[i];
      end
      if (rd_addr_b == ADDR_W'(i)) begin
        rd_data_b = LIVE_MASK[i] ? regs_q[i] : '0;
        busy_b    = busy_vec[i];
      end
    end
`ifdef GP_REG_FILE_BYPASS_EN
    // A forwarded write retires the pending flag unless it is re-locked now.
    byp_a = (|wr_sel) && (wr_addr == rd_addr_a);
    byp_b = (|wr_sel) && (wr_addr == rd_addr_b);
    if (byp_a) begin
      rd_data_a = wr_data;
      if (!(lock_en && (lock_addr == rd_addr_a))) busy_a = 1'b0;
    end
    if (byp_b) begin
      rd_data_b = wr_data;
      if (!(lock_en && (lock_addr == rd_addr_b))) busy_b = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_gp_reg_file.sv
module tb_gp_reg_file;
  import gp_regs_pkg::*;

`ifdef GP_REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Default build: 8-bit, 4 registers, no hard-wired register.
  logic       a_wr_en, a_lock_en, a_err_clr;
  addr_t      a_wr_addr, a_lock_addr, a_rd_addr_a, a_rd_addr_b;
  logic [7:0] a_wr_data, a_rd_data_a, a_rd_data_b;
  logic       a_busy_a, a_busy_b, a_err;
  logic [3:0] a_busy_vec;

  // Hard-wired register 0, 3 registers so address 3 is out of range.
  logic       z_wr_en, z_lock_en, z_err_clr;
  logic [1:0] z_wr_addr, z_lock_addr, z_rd_addr_a, z_rd_addr_b;
  logic [7:0] z_wr_data, z_rd_data_a, z_rd_data_b;
  logic       z_busy_a, z_busy_b, z_err;
  logic [2:0] z_busy_vec;

  gp_reg_file #(.DATA_W(8), .NUM_REGS(4), .ZERO_REG(0)) u_dut_a (
    .clk(clk), .rst(rst),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .rd_addr_a(a_rd_addr_a), .rd_addr_b(a_rd_addr_b),
    .rd_data_a(a_rd_data_a), .rd_data_b(a_rd_data_b),
    .lock_en(a_lock_en), .lock_addr(a_lock_addr),
    .busy_a(a_busy_a), .busy_b(a_busy_b), .busy_vec(a_busy_vec),
    .err(a_err), .err_clr(a_err_clr)
  );

  gp_reg_file #(.DATA_W(8), .NUM_REGS(3), .ZERO_REG(1)) u_dut_z (
    .clk(clk), .rst(rst),
    .wr_en(z_wr_en), .wr_addr(z_wr_addr), .wr_data(z_wr_data),
    .rd_addr_a(z_rd_addr_a), .rd_addr_b(z_rd_addr_b),
    .rd_data_a(z_rd_data_a), .rd_data_b(z_rd_data_b),
    .lock_en(z_lock_en), .lock_addr(z_lock_addr),
    .busy_a(z_busy_a), .busy_b(z_busy_b), .busy_vec(z_busy_vec),
    .err(z_err), .err_clr(z_err_clr)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    a_wr_en = 0; a_lock_en = 0; a_err_clr = 0;
    a_wr_addr = 0; a_lock_addr = 0; a_wr_data = 0; a_rd_addr_a = 0; a_rd_addr_b = 1;
    z_wr_en = 0; z_lock_en = 0; z_err_clr = 0;
    z_wr_addr = 0; z_lock_addr = 0; z_wr_data = 0; z_rd_addr_a = 0; z_rd_addr_b = 1;

    // Reset asserted mid-cycle: values visible without a clock edge.
    #13 rst = 1'b1;
    #1;
    chk("rst_a_r0", a_rd_data_a, 8'd2);
    chk("rst_a_r1", a_rd_data_b, 8'd4);
    chk("rst_a_busy", a_busy_vec, 4'b0000);
    chk("rst_a_err", a_err, 1'b0);
    chk("rst_z_r0", z_rd_data_a, 8'd0);
    chk("rst_z_r1", z_rd_data_b, 8'd4);
    chk("rst_z_busy", z_busy_vec, 3'b000);

    // Strobes presented while reset is high must be discarded.
    a_wr_en = 1; a_wr_addr = 0; a_wr_data = 8'hFF;
    a_lock_en = 1; a_lock_addr = 0;
    a_rd_addr_a = 2; a_rd_addr_b = 3;
    tick();
    chk("rst_a_r2", a_rd_data_a, 8'd8);
    chk("rst_a_r3", a_rd_data_b, 8'd16);
    a_wr_en = 0; a_lock_en = 0; rst = 1'b0; a_rd_addr_a = 0;
    #1;
    chk("rst_discard_r0", a_rd_data_a, 8'd2);
    chk("rst_discard_busy", a_busy_vec, 4'b0000);
    chk("rst_discard_err", a_err, 1'b0);
    tick();

    // Plain write to reg 2 (not locked, so err rises as well).
    a_wr_en = 1; a_wr_addr = 2; a_wr_data = 8'hA5; a_rd_addr_a = 2;
    #1;
    chk("wr_same_cycle", a_rd_data_a, BYP ? 8'hA5 : 8'd8);
    tick();
    a_wr_en = 0;
    #1;
    chk("wr_next_cycle", a_rd_data_a, 8'hA5);
    chk("orphan_wr_err", a_err, 1'b1);
    a_err_clr = 1;
    tick();
    a_err_clr = 0;
    #1;
    chk("err_clr", a_err, 1'b0);

    // Lock reg 1, write it two cycles later.
    a_lock_en = 1; a_lock_addr = 1;
    tick();
    a_lock_en = 0;
    #1;
    chk("lock1_busy_c1", a_busy_vec, 4'b0010);
    tick();
    chk("lock1_busy_c2", a_busy_vec, 4'b0010);
    a_wr_en = 1; a_wr_addr = 1; a_wr_data = 8'h3C; a_rd_addr_a = 1;
    #1;
    chk("lock1_busy_a_wr", a_busy_a, BYP ? 1'b0 : 1'b1);
    tick();
    a_wr_en = 0;
    #1;
    chk("lock1_busy_after", a_busy_vec, 4'b0000);
    chk("lock1_err", a_err, 1'b0);
    chk("lock1_data", a_rd_data_a, 8'h3C);

    // Collision on reg 3.
    a_lock_en = 1; a_lock_addr = 3;
    tick();
    a_lock_en = 0;
    #1;
    chk("lock3_busy", a_busy_vec, 4'b1000);
    a_lock_en = 1; a_lock_addr = 3; a_wr_en = 1; a_wr_addr = 3; a_wr_data = 8'h77; a_rd_addr_b = 3;
    #1;
    chk("coll_busy_b", a_busy_b, 1'b1);
    tick();
    a_lock_en = 0; a_wr_en = 0;
    #1;
    chk("coll_data", a_rd_data_b, 8'h77);
    chk("coll_busy", a_busy_vec, 4'b1000);
    chk("coll_err", a_err, 1'b0);
    a_lock_en = 1; a_lock_addr = 3;
    tick();
    a_lock_en = 0;
    #1;
    chk("relock_err", a_err, 1'b1);
    tick();
    chk("err_sticky", a_err, 1'b1);
    a_lock_en = 1; a_lock_addr = 3; a_err_clr = 1;
    tick();
    a_lock_en = 0; a_err_clr = 0;
    #1;
    chk("err_clr_vs_new", a_err, 1'b1);
    a_err_clr = 1;
    tick();
    a_err_clr = 0;
    #1;
    chk("err_clr2", a_err, 1'b0);
    chk("busy3_held", a_busy_vec, 4'b1000);
    a_wr_en = 1; a_wr_addr = 3; a_wr_data = 8'h11;
    tick();
    a_wr_en = 0;
    #1;
    chk("wr3_busy", a_busy_vec, 4'b0000);
    chk("wr3_err", a_err, 1'b0);
    chk("wr3_data", a_rd_data_b, 8'h11);

    // Dual read of reg 1 while it is written.
    a_lock_en = 1; a_lock_addr = 1;
    tick();
    a_lock_en = 0;
    a_wr_en = 1; a_wr_addr = 1; a_wr_data = 8'h5A; a_rd_addr_a = 1; a_rd_addr_b = 1;
    #1;
    chk("dual_rd_a", a_rd_data_a, BYP ? 8'h5A : 8'h3C);
    chk("dual_rd_b", a_rd_data_b, BYP ? 8'h5A : 8'h3C);
    chk("dual_busy_a", a_busy_a, BYP ? 1'b0 : 1'b1);
    chk("dual_busy_b", a_busy_b, BYP ? 1'b0 : 1'b1);
    tick();
    a_wr_en = 0;
    #1;
    chk("dual_rd_a_next", a_rd_data_a, 8'h5A);
    chk("dual_rd_b_next", a_rd_data_b, 8'h5A);
    chk("dual_busy_next", {a_busy_a, a_busy_b}, 2'b00);
    chk("dual_err", a_err, 1'b0);

    // Hard-wired register 0 ignores writes and locks.
    z_wr_en = 1; z_wr_addr = 0; z_wr_data = 8'hFF; z_lock_en = 1; z_lock_addr = 0; z_rd_addr_a = 0;
    #1;
    chk("z_r0_same", z_rd_data_a, 8'd0);
    tick();
    z_wr_en = 0; z_lock_en = 0;
    #1;
    chk("z_r0_data", z_rd_data_a, 8'd0);
    chk("z_r0_busy", z_busy_vec, 3'b000);
    chk("z_r0_err", z_err, 1'b0);

    // Out-of-range write.
    z_wr_en = 1; z_wr_addr = 3; z_wr_data = 8'h99; z_rd_addr_a = 1; z_rd_addr_b = 2;
    tick();
    z_wr_en = 0;
    #1;
    chk("z_oob_err", z_err, 1'b1);
    chk("z_oob_r1", z_rd_data_a, 8'd4);
    chk("z_oob_r2", z_rd_data_b, 8'd8);
    z_rd_addr_a = 3;
    #1;
    chk("z_oob_rd", z_rd_data_a, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
